uart_rxd_image: RTL and testbench
=================================

# uart_rxd_image

Byte-level UART receiver and frame parser for the image link. It deserialises the 8N1 stream on `RXD`, locates frames framed as header 0x01,0xFE / payload / trailer 0xFE,0x01, and writes every payload byte into a downstream write-side FIFO. It reports frame completion, framing errors and FIFO overflow as status. It sits between the board RX pin and the image-buffer FIFO, and mirrors the frame format produced by the image transmitter.

## Interface
- `CLK_FREQ_HZ`, 20_000_000, SYS_CLK frequency (50 ns period).
- `BAUD`, 256000, line rate.
- `IMG_W`, 240, image width in pixels.
- `IMG_H`, 320, image height in pixels; payload = IMG_W*IMG_H*2 bytes.
- `SYS_CLK` in 1: the single clock.
- `RST` in 1: reset, synchronous, active-high.
- `RXD` in 1: serial input, asynchronous, idle high.
- `WRFULL` in 1: FIFO full flag.
- `DATA_OUT` out 8: payload byte to FIFO.
- `WRREQ` out 1: FIFO write strobe, one cycle per byte.
- `WRCLK` out 1: FIFO write clock, = ~SYS_CLK.
- `FRAME_DONE` out 1: one-cycle pulse, frame fully received.
- `FRAME_ERR` out 1: one-cycle pulse, frame aborted.
- `OVERFLOW` out 1: sticky, a payload byte was dropped on WRFULL.
- `BUSY` out 1: high while the parser is past header detection.

## Operation
- BIT_DIV = CLK_FREQ_HZ/BAUD, integer-truncated (78 at defaults). The payload counter is wide enough for IMG_W*IMG_H*2 (18 bits at defaults).
- `RXD` passes through a 2-FF synchroniser. Both FFs reset to 1.
- **Bit engine states: IDLE, START, DATA, STOP.**
  - IDLE: a synchronised 1→0 transition moves to START.
  - START: count BIT_DIV/2 cycles, then resample. If the sample is low, go to DATA. If high, treat as a glitch and return to IDLE.
  - DATA: sample every BIT_DIV cycles, 8 bits, LSB first.
  - STOP: sample after BIT_DIV cycles. A 1 gives a valid byte. A 0 is a framing error and the byte is discarded. Either way, return to IDLE in the same edge, so the engine is ready for the next start bit from mid-stop.
- **Parser states: HUNT_H0, HUNT_H1, PAYLOAD, TRAIL0, TRAIL1.**
  - HUNT_H0: byte 0x01 → HUNT_H1. Any other byte is ignored.
  - HUNT_H1:
    - 0xFE → PAYLOAD. Clear the payload counter and OVERFLOW.
    - 0x01 → stay in HUNT_H1.
    - Any other byte → HUNT_H0.
  - PAYLOAD: each byte drives DATA_OUT and pulses WRREQ, unless WRFULL is high. In that case WRREQ stays low, OVERFLOW is set, and the byte still counts. After the last byte, go to TRAIL0.
  - TRAIL0: expect 0xFE → TRAIL1. A mismatch gives FRAME_ERR → HUNT_H0.
  - TRAIL1: expect 0x01 → FRAME_DONE → HUNT_H0. A mismatch gives FRAME_ERR → HUNT_H0.
- A framing error pulses FRAME_ERR and returns the parser to HUNT_H0 when the parser is in PAYLOAD/TRAIL0/TRAIL1. In HUNT states it is silently ignored.
- BUSY = parser in PAYLOAD, TRAIL0 or TRAIL1.

## Timing
- **Reset values:**
  - DATA_OUT = 0x00
  - WRREQ, FRAME_DONE, FRAME_ERR, OVERFLOW, BUSY = 0
  - Both FSMs in IDLE/HUNT_H0.
- Reset asserted mid-byte or mid-frame aborts everything with no pulses. Reception resumes on the first start edge after release.
- **Latency:**
  - The stop-bit sample edge is E.
  - The internal byte-valid flag is registered at E.
  - DATA_OUT/WRREQ/FRAME_DONE/FRAME_ERR are registered at E+1 and high for exactly one cycle.
- DATA_OUT holds its value until the next payload write.
- WRFULL is sampled in the same cycle the write decision is made (cycle E+1). No retry and no buffering.
- FRAME_DONE and FRAME_ERR are never high in the same cycle.
- Byte spacing is at least 9.5 bit times, so no back-to-back strobes occur.

## Configuration
- `UART_RXD_TRAILER_CHECK_EN`:
  - Defined: TRAIL0/TRAIL1 are checked as described above.
  - Undefined: TRAIL states are removed. FRAME_DONE pulses at E+1 of the last payload byte and the parser goes to HUNT_H0. Trailer bytes are then absorbed by the hunt rules (0xFE ignored, 0x01 → HUNT_H1, the next header 0x01 stays in HUNT_H1).

## Test plan
All scenarios use IMG_W=2, IMG_H=2 (8 payload bytes), 20 MHz, 256000 baud (78 cycles/bit).
- Frame 01 FE 00..07 FE 01 → 8 WRREQ pulses with DATA_OUT 0x00..0x07 in order, one FRAME_DONE, OVERFLOW=0.
- Leading junk 55 01 01 FE, then payload and trailer → first 01 and 55 are ignored, the frame is accepted, 8 writes.
- Stop bit forced to 0 on the 4th payload byte → FRAME_ERR pulse, only 3 writes, parser in HUNT_H0, the next good frame is accepted.
- WRFULL high during the 5th payload byte → 7 WRREQ pulses, OVERFLOW=1 until the next 01 FE header, FRAME_DONE still pulses.
- Trailer FE 02 → FRAME_ERR with the macro defined, FRAME_DONE with it undefined.
- RST pulsed during bit 3 of a payload byte → all outputs 0 next cycle, no pulses, a following full frame is received correctly.

Source files
------------

// File: rtl/uart_rxd_image.sv
// -----------------------------------------------------------------------------
// uart_rxd_image
//
// Byte-level 8N1 UART receiver and frame parser for the image link.
// Frames look like:  0x01 0xFE | IMG_W*IMG_H*2 payload bytes | 0xFE 0x01
// Every payload byte is written to a downstream write-side FIFO. Frame
// completion, aborted frames and FIFO overflow are reported as status.
//
// Configuration macro:
//   UART_RXD_TRAILER_CHECK_EN  defined   -> trailer 0xFE,0x01 is checked
//                              undefined -> FRAME_DONE fires on the last
//                                           payload byte, trailer bytes are
//                                           absorbed by the header hunt
//
// Ports:
//   SYS_CLK     in   single clock
//   RST         in   synchronous active-high reset
//   RXD         in   asynchronous serial input, idle high
//   WRFULL      in   FIFO full flag
//   DATA_OUT    out  [7:0] payload byte to FIFO (holds until next write)
//   WRREQ       out  one-cycle FIFO write strobe
//   WRCLK       out  FIFO write clock, inverted SYS_CLK
//   FRAME_DONE  out  one-cycle pulse, frame fully received
//   FRAME_ERR   out  one-cycle pulse, frame aborted
//   OVERFLOW    out  sticky, a payload byte was dropped on WRFULL
//   BUSY        out  parser is past header detection
// -----------------------------------------------------------------------------
module uart_rxd_image #(
  parameter int CLK_FREQ_HZ = 20_000_000,
  parameter int BAUD        = 256_000,
  parameter int IMG_W       = 240,
  parameter int IMG_H       = 320
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       WRFULL,
  output logic [7:0] DATA_OUT,
  output logic       WRREQ,
  output logic       WRCLK,
  output logic       FRAME_DONE,
  output logic       FRAME_ERR,
  output logic       OVERFLOW,
  output logic       BUSY
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int BIT_DIV   = CLK_FREQ_HZ / BAUD;
  localparam int CNT_W     = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam int PAY_BYTES = IMG_W * IMG_H * 2;
  localparam int PAY_W     = (PAY_BYTES > 2) ? $clog2(PAY_BYTES) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [PAY_W-1:0] PAY_LAST  = PAY_W'(PAY_BYTES - 1);

  localparam logic [7:0] SYNC_A = 8'h01;
  localparam logic [7:0] SYNC_B = 8'hFE;

  // The FIFO captures on the falling edge of SYS_CLK, mid-way through the
  // cycle in which DATA_OUT/WRREQ are stable.
  assign WRCLK = ~SYS_CLK;

  // ---------------------------------------------------------------------------
  // RXD synchroniser plus one history stage for falling-edge detection.
  // All stages reset to the idle-high level so release of reset never looks
  // like a start edge.
  // ---------------------------------------------------------------------------
  logic rxd_meta;
  logic rxd_sync;
  logic rxd_prev;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together at the edge; blocking assignments here would make the
  // result depend on statement order and simulate differently from hardware.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit engine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_t;

  bit_state_t       bit_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;   // assembled byte, stable until next DATA phase
  logic             byte_valid;  // one-cycle: shift_reg holds a good byte
  logic             line_err;    // one-cycle: stop bit sampled low

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      bit_state  <= B_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      byte_valid <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      // NOTE: strobes default low at the top of the block so each one is
      // high for exactly the single cycle in which a branch raises it.
      byte_valid <= 1'b0;
      line_err   <= 1'b0;

      unique case (bit_state)
        B_IDLE: begin
          baud_cnt <= '0;
          if (rxd_prev && !rxd_sync) begin
            bit_state <= B_START;
          end
        end

        // Wait half a bit, then re-check the start bit at its centre; a
        // high level here was a glitch.
        B_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            bit_state <= rxd_sync ? B_IDLE : B_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // One sample per bit at bit centre, LSB first.
        B_DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rxd_sync, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              bit_state <= B_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // Leave at mid-stop so the next start edge is never missed, even
        // when bytes arrive with minimal spacing.
        B_STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt  <= '0;
            bit_state <= B_IDLE;
            if (rxd_sync) begin
              byte_valid <= 1'b1;
            end else begin
              line_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          bit_state <= B_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    P_HUNT_H0,
    P_HUNT_H1,
`ifdef UART_RXD_TRAILER_CHECK_EN
    P_PAYLOAD,
    P_TRAIL0,
    P_TRAIL1
`else
    P_PAYLOAD
`endif
  } par_state_t;

  par_state_t       par_state;
  logic [PAY_W-1:0] pay_cnt;

  // BUSY is kept as a register that tracks "parser past the header"; every
  // transition into or out of PAYLOAD/TRAIL updates it alongside par_state.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      par_state  <= P_HUNT_H0;
      pay_cnt    <= '0;
      DATA_OUT   <= 8'h00;
      WRREQ      <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERFLOW   <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      WRREQ      <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;

      if (line_err) begin
        // A corrupted byte only matters once a frame is in progress; while
        // hunting for a header it is just noise.
        if (BUSY) begin
          FRAME_ERR <= 1'b1;
          par_state <= P_HUNT_H0;
          BUSY      <= 1'b0;
        end
      end else if (byte_valid) begin
        unique case (par_state)
          P_HUNT_H0: begin
            if (shift_reg == SYNC_A) begin
              par_state <= P_HUNT_H1;
            end
          end

          // A repeated 0x01 may itself be the real first header byte.
          P_HUNT_H1: begin
            if (shift_reg == SYNC_B) begin
              par_state <= P_PAYLOAD;
              pay_cnt   <= '0;
              OVERFLOW  <= 1'b0;
              BUSY      <= 1'b1;
            end else if (shift_reg != SYNC_A) begin
              par_state <= P_HUNT_H0;
            end
          end

          // A byte dropped on WRFULL still counts, keeping the frame
          // boundary aligned with the transmitter.
          P_PAYLOAD: begin
            if (WRFULL) begin
              OVERFLOW <= 1'b1;
            end else begin
              DATA_OUT <= shift_reg;
              WRREQ    <= 1'b1;
            end
            if (pay_cnt == PAY_LAST) begin
`ifdef UART_RXD_TRAILER_CHECK_EN
              par_state <= P_TRAIL0;
`else
              FRAME_DONE <= 1'b1;
              par_state  <= P_HUNT_H0;
              BUSY       <= 1'b0;
`endif
            end else begin
              pay_cnt <= pay_cnt + 1'b1;
            end
          end

`ifdef UART_RXD_TRAILER_CHECK_EN
          P_TRAIL0: begin
            if (shift_reg == SYNC_B) begin
              par_state <= P_TRAIL1;
            end else begin
              FRAME_ERR <= 1'b1;
              par_state <= P_HUNT_H0;
              BUSY      <= 1'b0;
            end
          end

          P_TRAIL1: begin
            if (shift_reg == SYNC_A) begin
              FRAME_DONE <= 1'b1;
            end else begin
              FRAME_ERR <= 1'b1;
            end
            par_state <= P_HUNT_H0;
            BUSY      <= 1'b0;
          end
`endif

          default: begin
            par_state <= P_HUNT_H0;
            BUSY      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rxd_image.sv
// -----------------------------------------------------------------------------
// tb_uart_rxd_image
//
// Scoreboard bench for uart_rxd_image with an 8-byte payload (2x2 image).
// The stimulus process pushes every expected DUT event (payload write, frame
// done, frame error) into a queue before serialising the bytes; a monitor
// samples the outputs on the falling clock edge and pops/compares each event
// the DUT presents. Status flags are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_uart_rxd_image;

  localparam int CLK_FREQ_HZ = 20_000_000;
  localparam int BAUD        = 256_000;
  localparam int IMG_W       = 2;
  localparam int IMG_H       = 2;
  localparam int BIT_DIV     = CLK_FREQ_HZ / BAUD;  // 78
  localparam int N_PAY       = IMG_W * IMG_H * 2;   // 8

  logic       SYS_CLK = 1'b0;
  logic       RST     = 1'b1;
  logic       RXD     = 1'b1;
  logic       WRFULL  = 1'b0;
  logic [7:0] DATA_OUT;
  logic       WRREQ;
  logic       WRCLK;
  logic       FRAME_DONE;
  logic       FRAME_ERR;
  logic       OVERFLOW;
  logic       BUSY;

  always #25 SYS_CLK = ~SYS_CLK;

  uart_rxd_image #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H)
  ) dut (
    .SYS_CLK   (SYS_CLK),
    .RST       (RST),
    .RXD       (RXD),
    .WRFULL    (WRFULL),
    .DATA_OUT  (DATA_OUT),
    .WRREQ     (WRREQ),
    .WRCLK     (WRCLK),
    .FRAME_DONE(FRAME_DONE),
    .FRAME_ERR (FRAME_ERR),
    .OVERFLOW  (OVERFLOW),
    .BUSY      (BUSY)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {EV_WR, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic consume(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    check({"event_expected_", k.name()}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (k == EV_WR) check("write_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: outputs are sampled half a cycle after the active edge.
  always @(negedge SYS_CLK) begin
    if (FRAME_DONE === 1'b1 || FRAME_ERR === 1'b1)
      check("done_err_exclusive", 32'(FRAME_DONE & FRAME_ERR), 32'd0);
    if (WRREQ === 1'b1)      consume(EV_WR, DATA_OUT);
    if (FRAME_DONE === 1'b1) consume(EV_DONE, 8'h00);
    if (FRAME_ERR === 1'b1)  consume(EV_ERR, 8'h00);
  end

  // ---------------------------------------------------------------------------
  // Serial stimulus (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic wait_bits(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RXD = 1'b0;
    wait_bits(BIT_DIV);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      wait_bits(BIT_DIV);
    end
    RXD = stop_bit;
    wait_bits(BIT_DIV);
    RXD = 1'b1;
    // A low stop bit needs the line back high before the next start edge.
    if (!stop_bit) wait_bits(BIT_DIV);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  // Queues the whole frame's expected events first (writes, then end_kind),
  // then sends the payload bytes base..base+7. WRFULL is held high for the
  // payload byte at index full_idx (-1 for none).
  task automatic payload(input logic [7:0] base, input int full_idx,
                         input ev_kind_t end_kind);
    for (int i = 0; i < N_PAY; i++)
      if (i != full_idx) expect_ev(EV_WR, base + 8'(i));
    expect_ev(end_kind, 8'h00);
    for (int i = 0; i < N_PAY; i++) begin
      WRFULL = (i == full_idx);
      send_ok(base + 8'(i));
      WRFULL = 1'b0;
    end
  endtask

  logic [7:0] part_byte = 8'h5A;

  initial begin
    #4_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    RST = 1'b1;
    wait_bits(5);
    check("rst_data_out",   32'(DATA_OUT),   32'h00);
    check("rst_wrreq",      32'(WRREQ),      32'd0);
    check("rst_frame_done", 32'(FRAME_DONE), 32'd0);
    check("rst_frame_err",  32'(FRAME_ERR),  32'd0);
    check("rst_overflow",   32'(OVERFLOW),   32'd0);
    check("rst_busy",       32'(BUSY),       32'd0);
    check("wrclk_inverted", 32'(WRCLK),      32'd1);
    RST = 1'b0;
    wait_bits(2 * BIT_DIV);

    // ---- clean frame 01 FE 00..07 FE 01 ----
    send_ok(8'h01);
    send_ok(8'hFE);
    check("busy_after_header", 32'(BUSY), 32'd1);
    payload(8'h00, -1, EV_DONE);
    send_ok(8'hFE);
    send_ok(8'h01);
    check("f1_overflow", 32'(OVERFLOW), 32'd0);
    check("f1_busy_idle", 32'(BUSY), 32'd0);

    // ---- leading junk 55 01 01 FE ----
    send_ok(8'h55);
    send_ok(8'h01);
    send_ok(8'h01);
    send_ok(8'hFE);
    check("f2_busy_after_header", 32'(BUSY), 32'd1);
    payload(8'h10, -1, EV_DONE);
    send_ok(8'hFE);
    send_ok(8'h01);
    check("f2_busy_idle", 32'(BUSY), 32'd0);

    // ---- stop bit low on 4th payload byte ----
    send_ok(8'h01);
    send_ok(8'hFE);
    expect_ev(EV_WR, 8'h20);
    expect_ev(EV_WR, 8'h21);
    expect_ev(EV_WR, 8'h22);
    expect_ev(EV_ERR, 8'h00);
    send_ok(8'h20);
    send_ok(8'h21);
    send_ok(8'h22);
    send_byte(8'h23, 1'b0);
    check("f3_busy_after_err", 32'(BUSY), 32'd0);
    check("f3_data_out_hold", 32'(DATA_OUT), 32'h22);

    // ---- WRFULL on 5th payload byte; next frame accepted ----
    send_ok(8'h01);
    send_ok(8'hFE);
    payload(8'h30, 4, EV_DONE);
    send_ok(8'hFE);
    send_ok(8'h01);
    check("f4_overflow_set", 32'(OVERFLOW), 32'd1);
    check("f4_busy_idle", 32'(BUSY), 32'd0);
    send_ok(8'h01);
    check("f4_overflow_sticky", 32'(OVERFLOW), 32'd1);
    send_ok(8'hFE);
    check("f5_overflow_cleared", 32'(OVERFLOW), 32'd0);
    check("f5_busy", 32'(BUSY), 32'd1);

    // ---- bad trailer FE 02 ----
`ifdef UART_RXD_TRAILER_CHECK_EN
    payload(8'h40, -1, EV_ERR);
`else
    payload(8'h40, -1, EV_DONE);
`endif
    send_ok(8'hFE);
    send_ok(8'h02);
    check("f5_busy_idle", 32'(BUSY), 32'd0);

    // ---- reset during bit 3 of a payload byte ----
    send_ok(8'h01);
    send_ok(8'hFE);
    expect_ev(EV_WR, 8'hA1);
    expect_ev(EV_WR, 8'hA2);
    send_ok(8'hA1);
    send_ok(8'hA2);
    RXD = 1'b0;
    wait_bits(BIT_DIV);
    for (int i = 0; i < 3; i++) begin
      RXD = part_byte[i];
      wait_bits(BIT_DIV);
    end
    RXD = part_byte[3];
    wait_bits(BIT_DIV / 2);
    check("f6_busy_before_rst", 32'(BUSY), 32'd1);
    RST = 1'b1;
    RXD = 1'b1;
    wait_bits(1);
    check("f6_rst_data_out",   32'(DATA_OUT),   32'h00);
    check("f6_rst_wrreq",      32'(WRREQ),      32'd0);
    check("f6_rst_frame_done", 32'(FRAME_DONE), 32'd0);
    check("f6_rst_frame_err",  32'(FRAME_ERR),  32'd0);
    check("f6_rst_overflow",   32'(OVERFLOW),   32'd0);
    check("f6_rst_busy",       32'(BUSY),       32'd0);
    RST = 1'b0;
    wait_bits(3 * BIT_DIV);
    send_ok(8'h01);
    send_ok(8'hFE);
    payload(8'h50, -1, EV_DONE);
    send_ok(8'hFE);
    send_ok(8'h01);

    wait_bits(2 * BIT_DIV);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(BUSY), 32'd0);
    check("final_overflow", 32'(OVERFLOW), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
